// File: rtl/branch_pc_unit.sv
// branch_pc_unit: resolves branches/JAL/JALR, owns the PC, counts taken
// conditional branches and raises a one-cycle misaligned-target trap.
// Ports: clk, rst_n (async low); instr_valid, stall, is_branch, is_jal,
//   is_jalr, funct3, imm, rs1, equal, a_lt_b_s, a_lt_b_u (in);
//   pc, pc_plus4, branch_taken, fetch_en, trap, trap_pc, trap_target,
//   taken_count (out).
module branch_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic             stall,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1,
  input  logic             equal,
  input  logic             a_lt_b_s,
  input  logic             a_lt_b_u,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             branch_taken,
  output logic             fetch_en,
  output logic             trap,
  output logic [31:0]      trap_pc,
  output logic [31:0]      trap_target,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      tpc_q, tpc_d;
  logic [31:0]      ttgt_q, ttgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        cond;
  logic        br_eff;
  logic        take;
  logic        advance;
  logic        misal;
  logic [31:0] target;
  logic [31:0] jalr_sum;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = equal;
      3'b001:  cond = ~equal;
      3'b100:  cond = a_lt_b_s;
      3'b101:  cond = ~a_lt_b_s;
      3'b110:  cond = a_lt_b_u;
      3'b111:  cond = ~a_lt_b_u;
      default: cond = 1'b0;
    endcase
  end

  // jal wins over jalr, jalr over branch when flags overlap
  assign br_eff   = is_branch & ~is_jal & ~is_jalr;
  assign take     = is_jal | is_jalr | (is_branch & cond);
  assign jalr_sum = rs1 + imm;
  assign target   = (is_jalr & ~is_jal)
                  ? {jalr_sum[31:1], 1'b0}
                  : pc_q + imm;
  assign misal    = target[1:0] != 2'b00;
  assign advance  = (state_q == RUN) & instr_valid & ~stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tpc_d   = tpc_q;
    ttgt_d  = ttgt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (advance) begin
          if (!take) begin
            pc_d = pc_q + 32'd4;
          end else if (misal) begin
            pc_d    = TRAP_VECTOR;
            tpc_d   = pc_q;
            ttgt_d  = target;
            state_d = TRAP;
          end else begin
            pc_d = target;
            if (br_eff && cnt_q != {CNT_W{1'b1}})
              cnt_d = cnt_q + 1'b1;
          end
        end
      end
      TRAP: state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      tpc_q   <= '0;
      ttgt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tpc_q   <= tpc_d;
      ttgt_q  <= ttgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign fetch_en     = state_q == RUN;
  assign trap         = state_q == TRAP;
  assign branch_taken = (state_q == RUN) & instr_valid & take;
  assign trap_pc      = tpc_q;
  assign trap_target  = ttgt_q;
  assign taken_count  = cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed vectors for branch_pc_unit, with a second
// instance at CNT_W=2 sharing all inputs to observe counter saturation.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, stall;
  logic        is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic [31:0] imm, rs1;
  logic        equal, a_lt_b_s, a_lt_b_u;

  logic [31:0] pc, pc_plus4, trap_pc, trap_target;
  logic        branch_taken, fetch_en, trap;
  logic [15:0] taken_count;

  logic [31:0] pc2, pc_plus4_2, trap_pc2, trap_target2;
  logic        branch_taken2, fetch_en2, trap2;
  logic [1:0]  taken_count2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_pc_unit dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .stall(stall),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .funct3(funct3), .imm(imm), .rs1(rs1),
    .equal(equal), .a_lt_b_s(a_lt_b_s), .a_lt_b_u(a_lt_b_u),
    .pc(pc), .pc_plus4(pc_plus4), .branch_taken(branch_taken),
    .fetch_en(fetch_en), .trap(trap), .trap_pc(trap_pc),
    .trap_target(trap_target), .taken_count(taken_count)
  );

  branch_pc_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .stall(stall),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .funct3(funct3), .imm(imm), .rs1(rs1),
    .equal(equal), .a_lt_b_s(a_lt_b_s), .a_lt_b_u(a_lt_b_u),
    .pc(pc2), .pc_plus4(pc_plus4_2), .branch_taken(branch_taken2),
    .fetch_en(fetch_en2), .trap(trap2), .trap_pc(trap_pc2),
    .trap_target(trap_target2), .taken_count(taken_count2)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctl();
    is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    funct3 = 3'b000; imm = '0; rs1 = '0;
    equal = 1'b0; a_lt_b_s = 1'b0; a_lt_b_u = 1'b0;
  endtask

  task automatic jal(input logic [31:0] off);
    clr_ctl();
    is_jal = 1'b1;
    imm    = off;
    step();
    clr_ctl();
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; stall = 1'b0;
    clr_ctl();
    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_fetch", {31'b0, fetch_en}, 32'd0);
    check("rst_trap", {31'b0, trap}, 32'd0);
    check("rst_taken", {31'b0, branch_taken}, 32'd0);
    check("rst_cnt", {16'b0, taken_count}, 32'd0);
    check("rst_tpc", trap_pc, 32'h0);
    check("rst_ttgt", trap_target, 32'h0);

    rst_n = 1'b1;
    #1;
    check("boot_fetch", {31'b0, fetch_en}, 32'd0);
    step();
    check("run_fetch", {31'b0, fetch_en}, 32'd1);
    check("run_pc0", pc, 32'h0);

    instr_valid = 1'b1;
    step(); check("seq_pc4", pc, 32'h4);
    step(); check("seq_pc8", pc, 32'h8);
    step(); check("seq_pc12", pc, 32'hC);
    check("seq_plus4", pc_plus4, 32'h10);

    jal(32'h34);
    check("jal_pc", pc, 32'h40);
    check("jal_nocnt", {16'b0, taken_count}, 32'd0);

    is_branch = 1'b1; funct3 = 3'b000; imm = 32'h20; equal = 1'b1;
    #1 check("beq_tk", {31'b0, branch_taken}, 32'd1);
    step();
    check("beq_pc", pc, 32'h60);
    check("beq_cnt", {16'b0, taken_count}, 32'd1);
    equal = 1'b0;
    #1 check("beq_nt", {31'b0, branch_taken}, 32'd0);
    step();
    check("beq_nt_pc", pc, 32'h64);
    check("beq_nt_cnt", {16'b0, taken_count}, 32'd1);

    funct3 = 3'b010; equal = 1'b1;
    #1 check("f010_nt", {31'b0, branch_taken}, 32'd0);

    jal(32'h1C);
    check("jal2_pc", pc, 32'h80);

    is_branch = 1'b1; funct3 = 3'b110; imm = 32'hFFFF_FFF8;
    a_lt_b_u = 1'b0; a_lt_b_s = 1'b1;
    step();
    check("bltu_pc", pc, 32'h84);
    jal(32'hFFFF_FFFC);
    check("jal3_pc", pc, 32'h80);
    is_branch = 1'b1; funct3 = 3'b100; imm = 32'hFFFF_FFF8;
    a_lt_b_u = 1'b0; a_lt_b_s = 1'b1;
    step();
    check("blt_pc", pc, 32'h78);
    check("blt_cnt", {16'b0, taken_count}, 32'd2);

    clr_ctl();
    is_jalr = 1'b1; rs1 = 32'h1003; imm = 32'h0;
    #1 check("jalr_tk", {31'b0, branch_taken}, 32'd1);
    step();
    check("trap_on", {31'b0, trap}, 32'd1);
    check("trap_fetch", {31'b0, fetch_en}, 32'd0);
    check("trap_tk", {31'b0, branch_taken}, 32'd0);
    check("trap_pcv", pc, 32'h100);
    check("trap_tpc", trap_pc, 32'h78);
    check("trap_tgt", trap_target, 32'h1002);
    step();
    check("trap_off", {31'b0, trap}, 32'd0);
    check("trap_run", {31'b0, fetch_en}, 32'd1);
    check("trap_hold", pc, 32'h100);
    check("trap_cnt", {16'b0, taken_count}, 32'd2);

    clr_ctl();
    is_branch = 1'b1; funct3 = 3'b001; imm = 32'h10; equal = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_tk", {31'b0, branch_taken}, 32'd1);
      step();
      check("stall_pc", pc, 32'h100);
    end
    stall = 1'b0;
    step();
    check("bne_pc", pc, 32'h110);
    check("bne_cnt", {16'b0, taken_count}, 32'd3);
    clr_ctl();
    step();
    check("bne_once_pc", pc, 32'h114);
    check("bne_once_cnt", {16'b0, taken_count}, 32'd3);

    is_jalr = 1'b1; rs1 = 32'h2002;
    step();
    check("trap2_on", {31'b0, trap}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_trap", {31'b0, trap}, 32'd0);
    check("arst_fetch", {31'b0, fetch_en}, 32'd0);
    check("arst_cnt", {16'b0, taken_count}, 32'd0);
    check("arst_tpc", trap_pc, 32'h0);
    clr_ctl();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("arst_boot", {31'b0, fetch_en}, 32'd0);
    step();
    check("arst_run", {31'b0, fetch_en}, 32'd1);

    is_branch = 1'b1; funct3 = 3'b000; imm = 32'h8; equal = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("sat16_cnt", {16'b0, taken_count}, i);
      check("sat2_cnt", {30'b0, taken_count2}, (i > 3) ? 3 : i);
    end
    check("sat_pc", pc, 32'h28);

    jal(32'hFFFF_FFD4);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Consumes the comparator flags (equal, signed/unsigned less-than) together with decoded control-transfer info from the back-end.
- Resolves conditional branches and JAL/JALR, and owns the architectural PC register.
- Raises a one-cycle instruction-address-misaligned trap.
- Sits between the execute comparators and the fetch stage; drives the PC into instruction memory and the link value (pc+4) into writeback.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC value loaded when a misaligned target is detected
CNT_W, 16, width of the saturating taken-branch counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
instr_valid  input  1  instruction at pc is valid and retires this cycle
stall  input  1  hold PC (pipeline/memory wait)
is_branch  input  1  conditional branch (B-type)
is_jal  input  1  JAL
is_jalr  input  1  JALR
funct3  input  3  branch condition select
imm  input  32  sign-extended immediate
rs1  input  32  rs1 operand (JALR base)
equal  input  1  comparator: rs1 == rs2
a_lt_b_s  input  1  comparator: signed rs1 < rs2
a_lt_b_u  input  1  comparator: unsigned rs1 < rs2
pc  output  32  current PC (registered)
pc_plus4  output  32  pc + 4, link value (combinational from pc)
branch_taken  output  1  control transfer taken this cycle (combinational)
fetch_en  output  1  instruction fetch enable
trap  output  1  misaligned-target trap pulse
trap_pc  output  32  PC of faulting instruction (registered)
trap_target  output  32  offending target address (registered)
taken_count  output  CNT_W  saturating count of taken conditional branches

Behaviour:
- States: BOOT, RUN, TRAP.
- Reset (rst_n low, asynchronous) forces:
  - pc = RESET_VECTOR, state = BOOT
  - trap_pc = 0, trap_target = 0, taken_count = 0
  - outputs: fetch_en = 0, trap = 0, branch_taken = 0
- Reset asserted mid-operation aborts any state immediately, TRAP included.
- BOOT: fetch_en = 0; moves to RUN unconditionally on the next edge. First fetch occurs one cycle after reset release.
- RUN: fetch_en = 1.
  - advance = instr_valid & ~stall.
  - No PC change when advance = 0; stall has priority over instr_valid.
- Branch condition by funct3:
  - 000 equal; 001 ~equal
  - 100 a_lt_b_s; 101 ~a_lt_b_s
  - 110 a_lt_b_u; 111 ~a_lt_b_u
  - 010/011 never taken
- Targets (32-bit modular arithmetic, wrap-around ignored):
  - branch and JAL: pc + imm
  - JALR: (rs1 + imm) with bit 0 cleared
- Priority if the decode flags are not one-hot: is_jal > is_jalr > is_branch.
- branch_taken = RUN & instr_valid & (is_jal | is_jalr | (is_branch & cond)). It is combinational and independent of stall.
- Misaligned: target[1:0] != 0 after the JALR bit-0 clear (no C extension).
- On an advance edge:
  - not taken: pc <= pc + 4
  - taken and aligned: pc <= target
  - taken and misaligned: pc <= TRAP_VECTOR; trap_pc <= pc; trap_target <= target; state <= TRAP
- TRAP: lasts exactly one cycle regardless of stall/instr_valid.
  - trap = 1, fetch_en = 0, branch_taken = 0
  - then moves to RUN
- taken_count:
  - increments on an advance edge with is_branch, cond true, and aligned target
  - saturates at all-ones
  - jumps and trapping branches do not count
- pc_plus4 = pc + 4 in all states; 32'hFFFF_FFFC wraps to 0.

Test Plan:
- Reset release with RESET_VECTOR=0 -> BOOT cycle fetch_en=0, pc=0; next cycle fetch_en=1; three non-branch advances -> pc 4, 8, 12.
- pc=0x40, BEQ imm=0x20, equal=1 -> branch_taken=1, pc=0x60, taken_count=1; repeat with equal=0 -> pc=0x64, count unchanged.
- pc=0x80, BLTU vs BLT with rs1=0xFFFF_FFFF, rs2=1 (a_lt_b_u=0, a_lt_b_s=1), imm=-8:
  - BLTU not taken -> pc=0x84
  - BLT taken -> pc=0x78
- JALR rs1=0x1003, imm=0 -> target 0x1002 misaligned:
  - next cycle trap=1, fetch_en=0, pc=0x100, trap_pc=old pc, trap_target=0x1002
  - following cycle trap=0, RUN
  - taken_count unchanged
- Taken BNE with stall=1 held 3 cycles -> branch_taken=1 each cycle, pc unchanged; stall drops -> pc=target once, taken_count +1 once.
- CNT_W=2, five taken branches -> taken_count 1, 2, 3, 3, 3.
- rst_n pulsed low asynchronously during TRAP -> pc=RESET_VECTOR immediately, trap=0, BOOT on release.
